fsqrt_arbiter: RTL and testbench
================================

# fsqrt_arbiter

Round-robin arbiter that shares one pipelined `fsqrt` unit among `N_REQ` requesters. Each requester offers a 32-bit IEEE-754 single-precision operand with a valid/ready handshake. The arbiter issues at most one operand per cycle into the shared `fsqrt`, tracks the issuing requester through a tag pipeline matched to the unit's latency, and returns each result to its originator. It sits between the core's FP issue ports and the single `fsqrt` instance.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `LATENCY`, default 2: cycles from `fsqrt_x` being presented to the matching `fsqrt_y`; must be at least 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N_REQ: bit i is set when requester i offers an operand.
- `req_x`, in, 32*N_REQ: operands; requester i uses bits [32i+31:32i].
- `req_ready`, out, N_REQ: one-hot or zero; bit i is the grant to requester i this cycle.
- `fsqrt_x`, out, 32: operand to the shared `fsqrt` `x` input (combinational).
- `fsqrt_y`, in, 32: result from the shared `fsqrt` `y` output.
- `resp_valid`, out, N_REQ: registered; bit i pulses for one cycle when requester i's result is on `resp_y`.
- `resp_y`, out, 32: registered result, broadcast to all requesters.
- `idle`, out, 1: set when no operation is in flight and `resp_valid` is all zero.

## Operation
- State:
  - Round-robin pointer `ptr`, of width clog2(N_REQ).
  - Tag pipeline of `LATENCY` stages, each holding {valid, index}.
  - `resp_valid` and `resp_y` registers.
- Grant (combinational):
  - Scan requesters starting at `ptr`, wrapping modulo N_REQ.
  - The first i with `req_valid[i]` set gets `req_ready[i]=1`; all other ready bits are 0.
  - If no request is valid, `req_ready` is all zero.
  - `req_ready` depends on `req_valid`. A requester must not wait for ready before asserting valid.
- Issue: the handshake is `req_valid[i] & req_ready[i]`.
  - On issue, `fsqrt_x` = `req_x[i]`. With no issue, `fsqrt_x` = 32'h0.
  - Tag stage 0 loads {1, i}. With no issue it loads {0, x}.
  - `ptr` becomes (i+1) mod N_REQ. With no issue, `ptr` holds.
- The tag pipeline shifts one stage every cycle. It never stalls, because `fsqrt` cannot stall.
- Return: when the last tag stage is {1, j} at an edge:
  - `resp_valid` becomes one-hot at bit j.
  - `resp_y` captures `fsqrt_y`.
  - Otherwise `resp_valid` becomes 0 and `resp_y` holds its previous value.
- Responses have no backpressure. Requesters must accept `resp_valid` unconditionally.
- Operand handling:
  - Operands are passed unmodified, including 0, negatives and NaN.
  - Result correctness is the responsibility of `fsqrt`.
- A requester may hold `req_valid` continuously. It receives one grant per round-robin turn, so with K active requesters, each active one is granted once every K cycles.
- A requester that drops `req_valid` before being granted loses nothing. No state is kept for it.

## Timing
- Reset values (applied at the first edge with `rst`=1):
  - `ptr`=0 and all tag valid bits 0.
  - `resp_valid`=0 and `resp_y`=32'h0.
  - `idle`=1.
- `req_ready` and `fsqrt_x` are combinational, so they are also zero during reset when `req_valid` is zero.
- `req_ready` is forced to 0 while `rst`=1. No issue can occur during reset.
- Latency: handshake in cycle t gives `resp_valid` high during cycle t+LATENCY+1.
- Throughput: one issue per cycle, sustained. Back-to-back issues give back-to-back responses, in issue order.
- Reset mid-operation: all in-flight tags are discarded. `fsqrt_y` values that arrive later never produce `resp_valid`.
- Pointer wrap: a grant to N_REQ-1 sets `ptr`=0.
- Simultaneous events:
  - An issue and a response in the same cycle are independent. Both happen.
  - The same requester may be issuing while receiving an earlier result.
- `idle` is combinational: the NOR of all tag valid bits and all `resp_valid` bits. It does not consider `req_valid`.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst` for 2 cycles with all `req_valid` asserted.
  - Required: `req_ready`=0, `resp_valid`=0, `resp_y`=0 and `idle`=1 throughout. Requester 0 is granted in the first cycle after reset.
- Single request:
  - Stimulus: requester 2 presents 32'h40400000 (3.0) for one cycle, with LATENCY=2.
  - Required: `req_ready`=4'b0100 that cycle. Three cycles later, `resp_valid`=4'b0100 and `resp_y`=32'h3FDDB3D7 for exactly one cycle.
- Round-robin fairness:
  - Stimulus: all four requesters held valid for 8 cycles. Operands: r0=32'h40800000, r1=32'h40000000, r2=32'h0, r3=32'h437F0000.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required responses, in order: 32'h40000000, 32'h3FB504F3, 32'h0, 32'h417F7FE0, each tagged to its requester.
- Wrap and skip:
  - Stimulus: `ptr`=3, then only r1 and r3 valid.
  - Required: r3 granted first, then r1, then r3.
- Reset mid-flight:
  - Stimulus: issue 32'h40A00000 from r1, then assert `rst` in the next cycle.
  - Required: no `resp_valid` for that operation. `idle`=1 after reset.
- Back-to-back from one requester:
  - Stimulus: only r0 valid for 5 cycles with distinct operands.
  - Required: 5 consecutive `resp_valid`=4'b0001 pulses, in operand order.

Source files
------------

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined fsqrt unit among N_REQ requesters.
// A tag pipeline matched to the unit latency routes each result back to its issuer.
module fsqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           fsqrt_x,
    input  logic [31:0]           fsqrt_y,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_y,
    output logic                  idle
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      sel;
    logic               found;
    logic [LATENCY-1:0] tag_valid;
    logic [IW-1:0]      tag_idx [LATENCY];

    // Two passes give the wrap: first requesters at or above ptr, then from 0.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && (IW'(i) >= ptr)) begin
                    found = 1'b1;
                    sel   = IW'(i);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i]) begin
                    found = 1'b1;
                    sel   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        fsqrt_x   = 32'h0;
        for (int i = 0; i < N_REQ; i++) begin
            if (found && (sel == IW'(i))) begin
                req_ready[i] = 1'b1;
                fsqrt_x      = req_x[32*i +: 32];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            tag_valid  <= '0;
            resp_valid <= '0;
            resp_y     <= 32'h0;
        end else begin
            if (found) begin
                ptr <= (sel == IW'(N_REQ-1)) ? '0 : sel + 1'b1;
            end
            tag_valid[0] <= found;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
            for (int j = 0; j < N_REQ; j++) begin
                resp_valid[j] <= tag_valid[LATENCY-1] && (tag_idx[LATENCY-1] == IW'(j));
            end
            if (tag_valid[LATENCY-1]) begin
                resp_y <= fsqrt_y;
            end
        end
    end

    // NOTE: the index payload is left unreset; it is only observed when its valid bit is set.
    always_ff @(posedge clk) begin
        tag_idx[0] <= sel;
        for (int i = 1; i < LATENCY; i++) begin
            tag_idx[i] <= tag_idx[i-1];
        end
    end

    assign idle = ~(|tag_valid) & ~(|resp_valid);

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Self-checking bench for fsqrt_arbiter: directed scenarios then randomized traffic,
// compared cycle by cycle against a queue-based round-robin/scoreboard model.
module tb_fsqrt_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_x;
    logic [N-1:0]      req_ready;
    logic [31:0]       fsqrt_x;
    logic [31:0]       fsqrt_y;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_y;
    logic              idle;

    always #5 clk = ~clk;

    fsqrt_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .fsqrt_x    (fsqrt_x),
        .fsqrt_y    (fsqrt_y),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .idle       (idle)
    );

    // Stand-in for the shared unit: exact results for known operands, a fixed scramble otherwise.
    function automatic logic [31:0] sqrt_model(input logic [31:0] x);
        case (x)
            32'h40400000: return 32'h3FDDB3D7;
            32'h40800000: return 32'h40000000;
            32'h40000000: return 32'h3FB504F3;
            32'h00000000: return 32'h00000000;
            32'h437F0000: return 32'h417F7FE0;
            32'h40A00000: return 32'h400F1BBD;
            default:      return x ^ 32'h5A3C_96E1;
        endcase
    endfunction

    logic [31:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= sqrt_model(fsqrt_x);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fsqrt_y = fpipe[LAT-1];

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] y;
    } pend_t;

    pend_t       pend [$];
    int          m_ptr;
    int          cyc;
    int          checks;
    int          failures;
    logic [31:0] m_resp_y;
    bit          known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check combinational and registered outputs, then advance the model at the edge.
    task automatic tick();
        int          g;
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        logic [31:0]  exp_x;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (m_ptr + k) % N;
                v = req_valid >> r;
                if (g < 0 && v[0]) g = r;
            end
        end
        exp_ready = '0;
        exp_x     = 32'h0;
        if (g >= 0) begin
            exp_ready = N'(1) << g;
            exp_x     = 32'(req_x >> (32*g));
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("fsqrt_x", fsqrt_x, exp_x);

        exp_rv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv   = N'(1) << pend[0].idx;
            m_resp_y = pend[0].y;
            void'(pend.pop_front());
        end
        if (known) begin
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("resp_y", resp_y, m_resp_y);
            check("idle", 32'(idle), 32'((pend.size() == 0) && (exp_rv == '0)));
        end

        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_ptr    = 0;
            m_resp_y = 32'h0;
            known    = 1'b1;
        end else if (g >= 0) begin
            pend.push_back('{cyc + LAT + 1, g, sqrt_model(exp_x)});
            m_ptr = (g + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_resp_y = 32'h0;
        known    = 1'b0;

        // Reset with every requester asking: nothing may be granted.
        rst       = 1'b1;
        req_valid = '1;
        req_x     = {32'h437F0000, 32'h00000000, 32'h40000000, 32'h40800000};
        repeat (2) tick();
        rst = 1'b0;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Single request from r2; leaves ptr at 3.
        req_x[95:64] = 32'h40400000;
        req_valid    = 4'b0100;
        tick();
        check("single_ptr_model", 32'(m_ptr), 32'd3);
        req_valid = '0;
        repeat (4) tick();

        // Wrap and skip: r3, r1, r3.
        req_valid = 4'b1010;
        repeat (3) tick();
        req_valid = '0;
        repeat (4) tick();

        // Round-robin fairness with all four valid.
        req_x     = {32'h437F0000, 32'h00000000, 32'h40000000, 32'h40800000};
        req_valid = '1;
        repeat (8) tick();
        req_valid = '0;
        repeat (4) tick();

        // Back-to-back from r0 with distinct operands.
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            req_x[31:0] = $urandom ^ i;
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Reset one cycle after an issue: the result must never surface.
        req_x[63:32] = 32'h40A00000;
        req_valid    = 4'b0010;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("idle_after_reset", 32'(idle), 32'd1);

        // Randomized traffic with occasional resets.
        repeat (400) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_x[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            end
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
